// File: rtl/pipeline_control_unit_pkg.sv
//------------------------------------------------------------------------------
// pipeline_control_unit_pkg
// Shared core types and constants for the pipeline stall/flush controller.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package pipeline_control_unit_pkg;

    localparam int          REG_IDX_W = 5;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MC_BUSY  = 2'd1,
        MEM_WAIT = 2'd2
    } ctrl_state_t;

    // A load in EXE whose destination is read by the instruction in ID.
    function automatic logic load_use_hazard(
        input logic                 mem_read,
        input logic [REG_IDX_W-1:0] rd,
        input logic [REG_IDX_W-1:0] rs1,
        input logic [REG_IDX_W-1:0] rs2,
        input logic                 use_rs1,
        input logic                 use_rs2
    );
        return mem_read && (rd != '0) &&
               ((use_rs1 && (rs1 == rd)) || (use_rs2 && (rs2 == rd)));
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipeline_control_unit_stall_perf_counter.sv
//------------------------------------------------------------------------------
// pipeline_control_unit_stall_perf_counter
// Saturating event counter that holds at all-ones.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pipeline_control_unit_stall_perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (en_i && (count_q != {CNT_W{1'b1}})) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/pipeline_control_unit.sv
//------------------------------------------------------------------------------
// pipeline_control_unit
// Stall/flush controller: memory waits, multi-cycle ops, branches, load-use.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pipeline_control_unit
    import pipeline_control_unit_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [REG_IDX_W-1:0] rs1_id,
    input  logic [REG_IDX_W-1:0] rs2_id,
    input  logic                 use_rs1_id,
    input  logic                 use_rs2_id,
    input  logic [REG_IDX_W-1:0] rd_exe,
    input  logic                 mem_read_exe,
    input  logic                 mc_op_exe,
    input  logic                 mc_done,
    input  logic                 branch_taken_exe,
    input  logic                 dmem_req_mem,
    input  logic                 dmem_ack,
    output logic                 stall_if,
    output logic                 stall_id,
    output logic                 stall_exe,
    output logic                 stall_mem,
    output logic                 flush_id,
    output logic                 flush_exe,
    output logic                 flush_mem,
    output logic                 flush_wb,
    output logic                 mc_start,
    output logic                 bus_error,
    output logic [CNT_W-1:0]     stall_cycles
);

    localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);

    ctrl_state_t      state_q, state_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             pending_q, pending_d;
    logic             done_held_q, done_held_d;
    logic             bus_error_q, bus_error_d;

    logic w_timeout_hit;
    logic w_mem_wait;
    logic w_mc_start;
    logic w_mc_stall;
    logic w_lu_stall;
    logic w_br_flush;
    logic w_stall_exe;

    always_comb begin
        w_timeout_hit = (state_q == MEM_WAIT) && (tmo_q == TMO_W'(MEM_TIMEOUT));
        w_mem_wait    = dmem_req_mem && !dmem_ack && !w_timeout_hit;

        // done_held blocks a second start for an op that finished under a memory wait
        w_mc_start    = mc_op_exe && !w_mem_wait && !pending_q && !done_held_q &&
                        (state_q != MC_BUSY);
        w_mc_stall    = !w_mem_wait && (w_mc_start || (pending_q && !mc_done));
        w_stall_exe   = w_mem_wait || w_mc_stall;

        w_br_flush    = branch_taken_exe && !w_stall_exe;
        w_lu_stall    = !w_stall_exe && !branch_taken_exe &&
                        load_use_hazard(mem_read_exe, rd_exe, rs1_id, rs2_id,
                                        use_rs1_id, use_rs2_id);
    end

    always_comb begin
        pending_d   = pending_q;
        done_held_d = done_held_q;
        if (!w_stall_exe) begin
            done_held_d = 1'b0;
        end
        if (w_mc_start) begin
            pending_d = 1'b1;
        end else if (pending_q && mc_done) begin
            pending_d = 1'b0;
            if (w_mem_wait) begin
                done_held_d = 1'b1;
            end
        end

        if (w_mem_wait) begin
            state_d = MEM_WAIT;
        end else if (pending_d) begin
            state_d = MC_BUSY;
        end else begin
            state_d = IDLE;
        end

        tmo_d       = w_mem_wait ? (tmo_q + TMO_W'(1)) : '0;
        bus_error_d = bus_error_q || (w_timeout_hit && dmem_req_mem && !dmem_ack);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            tmo_q       <= '0;
            pending_q   <= 1'b0;
            done_held_q <= 1'b0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            pending_q   <= pending_d;
            done_held_q <= done_held_d;
            bus_error_q <= bus_error_d;
        end
    end

    // Outputs are forced low while reset is held so nothing leaks from stale inputs.
    assign stall_if  = reset_n && (w_stall_exe || w_lu_stall);
    assign stall_id  = reset_n && w_stall_exe;
    assign stall_exe = reset_n && w_stall_exe;
    assign stall_mem = reset_n && w_mem_wait;
    assign flush_id  = reset_n && w_br_flush;
    assign flush_exe = reset_n && (w_br_flush || w_lu_stall);
    assign flush_mem = reset_n && w_mc_stall;
    assign flush_wb  = reset_n && w_mem_wait;
    assign mc_start  = reset_n && w_mc_start;
    assign bus_error = bus_error_q;

    pipeline_control_unit_stall_perf_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .en_i    (stall_if),
        .count_o (stall_cycles)
    );

endmodule

`default_nettype wire
